// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider. Each channel divides the system clock by a
// shadowed divisor and produces a registered square or pulse output plus a wrap strobe.
module prog_clock_divider #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 20
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH*CNT_W-1:0] divisor,
  input  logic [NUM_CH-1:0]       mode,
  input  logic                    sync,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick
);

  localparam logic [CNT_W-1:0] One = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0][CNT_W-1:0] dact_q, dact_d;
  logic [NUM_CH-1:0]            tick_q, tick_d;
  logic [NUM_CH-1:0]            clk_out_q, clk_out_d;
  logic [NUM_CH-1:0]            mode_q, mode_d;

  always_comb begin
    cnt_d     = cnt_q;
    dact_d    = dact_q;
    tick_d    = '0;
    clk_out_d = '0;
    mode_d    = mode;
    for (int i = 0; i < NUM_CH; i++) begin
      logic sq_base;
      // A channel leaving pulse mode restarts its square wave from low.
      sq_base = mode_q[i] ? 1'b0 : clk_out_q[i];
      if (sync || !en[i] || (dact_q[i] == '0)) begin
        // Idle, restart or stalled: keep tracking the divisor input.
        cnt_d[i]  = '0;
        dact_d[i] = divisor[i*CNT_W +: CNT_W];
      end else if (cnt_q[i] == dact_q[i] - One) begin
        cnt_d[i]     = '0;
        dact_d[i]    = divisor[i*CNT_W +: CNT_W];
        tick_d[i]    = 1'b1;
        clk_out_d[i] = mode[i] ? 1'b1 : ~sq_base;
      end else begin
        cnt_d[i]     = cnt_q[i] + One;
        clk_out_d[i] = mode[i] ? 1'b0 : sq_base;
      end
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      dact_q    <= '0;
      tick_q    <= '0;
      clk_out_q <= '0;
      mode_q    <= '0;
    end else begin
      cnt_q     <= cnt_d;
      dact_q    <= dact_d;
      tick_q    <= tick_d;
      clk_out_q <= clk_out_d;
      mode_q    <= mode_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed bench for prog_clock_divider with two channels; expectations are hand-derived
// edge counts relative to each scenario's starting point.
module tb_prog_clock_divider;

  localparam int unsigned NCh = 2;
  localparam int unsigned Cw  = 20;

  logic              clock = 1'b0;
  logic              rst;
  logic [NCh-1:0]    en;
  logic [NCh*Cw-1:0] divisor;
  logic [NCh-1:0]    mode;
  logic              sync;
  logic [NCh-1:0]    clk_out;
  logic [NCh-1:0]    tick;

  int n_cmp = 0;
  int n_bad = 0;

  prog_clock_divider #(.NUM_CH(NCh), .CNT_W(Cw)) dut (
    .clock   (clock),
    .rst     (rst),
    .en      (en),
    .divisor (divisor),
    .mode    (mode),
    .sync    (sync),
    .clk_out (clk_out),
    .tick    (tick)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    en      = 2'b11;
    mode    = 2'b10;
    sync    = 1'b0;
    divisor = '0;
    divisor[19:0]  = 20'd5;
    divisor[39:20] = 20'd3;
    #1 rst = 1'b0;
    #49;
    n_cmp++;
    if (clk_out !== 2'b00) begin
      n_bad++; $display("FAIL reset_clk_out: got %b expected 00", clk_out);
    end
    n_cmp++;
    if (tick !== 2'b00) begin
      n_bad++; $display("FAIL reset_tick: got %b expected 00", tick);
    end
    #50 rst = 1'b1;  // released at 100 ns, a falling clock edge
  endtask

  // ch0 square /5, ch1 pulse /3; edge k counted after the divisor-capture edge.
  task automatic test_square_pulse();
    step();
    n_cmp++;
    if ({clk_out, tick} !== 4'b0000) begin
      n_bad++; $display("FAIL capture_edge: got %b expected 0000", {clk_out, tick});
    end
    for (int k = 1; k <= 30; k++) begin
      logic [1:0] et, ec;
      step();
      et = {k % 3 == 0, k % 5 == 0};
      ec = {k % 3 == 0, (k / 5) % 2 == 1};
      n_cmp++;
      if (tick !== et) begin
        n_bad++; $display("FAIL sq_pulse_tick k=%0d: got %b expected %b", k, tick, et);
      end
      n_cmp++;
      if (clk_out !== ec) begin
        n_bad++; $display("FAIL sq_pulse_clk k=%0d: got %b expected %b", k, clk_out, ec);
      end
    end
  endtask

  // ch0 divisor 5->2 while cnt=1: current period still ends 5 edges after its start.
  task automatic test_divisor_change();
    step();
    divisor[19:0] = 20'd2;
    for (int m = 1; m <= 10; m++) begin
      logic et0, ec0, e1;
      int   k;
      step();
      k   = 31 + m;
      et0 = (m >= 4) && ((m - 4) % 2 == 0);
      ec0 = (m >= 4) && (((m - 4) / 2) % 2 == 0);
      e1  = (k % 3 == 0);
      n_cmp++;
      if (tick[0] !== et0 || clk_out[0] !== ec0) begin
        n_bad++;
        $display("FAIL divchg_ch0 m=%0d: got t%b c%b expected t%b c%b",
                 m, tick[0], clk_out[0], et0, ec0);
      end
      n_cmp++;
      if (tick[1] !== e1 || clk_out[1] !== e1) begin
        n_bad++;
        $display("FAIL divchg_ch1 m=%0d: got t%b c%b expected t%b c%b",
                 m, tick[1], clk_out[1], e1, e1);
      end
    end
  endtask

  task automatic test_sync();
    divisor[19:0]  = 20'd4;
    divisor[39:20] = 20'd4;
    mode = 2'b00;
    sync = 1'b1;
    step();
    sync = 1'b0;
    n_cmp++;
    if ({clk_out, tick} !== 4'b0000) begin
      n_bad++; $display("FAIL sync_clear: got %b expected 0000", {clk_out, tick});
    end
    for (int n = 1; n <= 8; n++) begin
      logic [1:0] et, ec;
      step();
      et = (n == 4 || n == 8) ? 2'b11 : 2'b00;
      ec = (n >= 4 && n < 8) ? 2'b11 : 2'b00;
      n_cmp++;
      if (tick !== et || clk_out !== ec) begin
        n_bad++;
        $display("FAIL sync_align n=%0d: got t%b c%b expected t%b c%b", n, tick, clk_out, et, ec);
      end
    end
  endtask

  task automatic test_enable();
    for (int n = 9; n <= 14; n++) step();
    n_cmp++;
    if (clk_out[0] !== 1'b1) begin
      n_bad++; $display("FAIL en_pre_high: got %b expected 1", clk_out[0]);
    end
    en = 2'b10;
    divisor[19:0] = 20'd5;
    for (int e = 1; e <= 3; e++) begin
      step();
      n_cmp++;
      if (clk_out[0] !== 1'b0 || tick[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL en_low e=%0d: got c%b t%b expected c0 t0", e, clk_out[0], tick[0]);
      end
    end
    en = 2'b11;
    for (int r = 1; r <= 5; r++) begin
      logic ex;
      step();
      ex = (r == 5);
      n_cmp++;
      if (clk_out[0] !== ex || tick[0] !== ex) begin
        n_bad++;
        $display("FAIL en_resume r=%0d: got c%b t%b expected c%b t%b",
                 r, clk_out[0], tick[0], ex, ex);
      end
    end
  endtask

  task automatic test_div0_div1();
    en = 2'b10;
    divisor[19:0] = 20'd0;
    step();
    en = 2'b11;
    for (int c = 1; c <= 4; c++) begin
      step();
      n_cmp++;
      if (clk_out[0] !== 1'b0 || tick[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL div0_stall c=%0d: got c%b t%b expected c0 t0", c, clk_out[0], tick[0]);
      end
    end
    en = 2'b10;
    divisor[19:0] = 20'd1;
    step();
    en = 2'b11;
    for (int c = 1; c <= 4; c++) begin
      logic ec;
      step();
      ec = (c % 2 == 1);
      n_cmp++;
      if (clk_out[0] !== ec || tick[0] !== 1'b1) begin
        n_bad++;
        $display("FAIL div1_square c=%0d: got c%b t%b expected c%b t1", c, clk_out[0], tick[0], ec);
      end
    end
    mode[0] = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step();
      n_cmp++;
      if (clk_out[0] !== 1'b1 || tick[0] !== 1'b1) begin
        n_bad++;
        $display("FAIL div1_pulse c=%0d: got c%b t%b expected c1 t1", c, clk_out[0], tick[0]);
      end
    end
  endtask

  task automatic test_async_reset();
    mode[0] = 1'b0;
    divisor[19:0] = 20'd5;
    for (int c = 0; c < 7; c++) step();
    @(negedge clock);
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({clk_out, tick} !== 4'b0000) begin
      n_bad++; $display("FAIL async_rst_now: got %b expected 0000", {clk_out, tick});
    end
    #10;
    n_cmp++;
    if ({clk_out, tick} !== 4'b0000) begin
      n_bad++; $display("FAIL async_rst_hold: got %b expected 0000", {clk_out, tick});
    end
    @(negedge clock);
    rst = 1'b1;
    step();
    for (int k = 1; k <= 5; k++) begin
      logic [1:0] et, ec;
      step();
      et = {k == 4, k == 5};
      ec = {k >= 4, k >= 5};
      n_cmp++;
      if (tick !== et || clk_out !== ec) begin
        n_bad++;
        $display("FAIL rst_restart k=%0d: got t%b c%b expected t%b c%b", k, tick, clk_out, et, ec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_square_pulse();
    test_divisor_change();
    test_sync();
    test_enable();
    test_div0_div1();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prog_clock_divider.md
PROG_CLOCK_DIVIDER -- requirements
Module: prog_clock_divider

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent divider channels (1..16).
REQ-002 Parameter CNT_W, default 20, width of each channel's divisor and counter.
REQ-003 Port clock  input  1  single system clock; all state on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-low.
REQ-005 Port en  input  NUM_CH  per-channel enable; bit i controls channel i.
REQ-006 Port divisor  input  NUM_CH*CNT_W  per-channel divisor; channel i uses bits [i*CNT_W +: CNT_W].
REQ-007 Port mode  input  NUM_CH  per-channel output mode: 0 = square (toggle), 1 = pulse.
REQ-008 Port sync  input  1  synchronous restart of all channels, for phase alignment.
REQ-009 Port clk_out  output  NUM_CH  registered divided output per channel.
REQ-010 Port tick  output  NUM_CH  registered one-cycle strobe per channel at each counter wrap.

Function
REQ-011 Each channel SHALL hold a CNT_W-bit counter cnt and a CNT_W-bit shadow divisor dact.
REQ-012 dact SHALL load from the divisor input in three cases:
- cycles where en[i]=0;
- cycles where sync=1;
- the cycle in which cnt wraps.
dact SHALL hold at all other times. A divisor change therefore takes effect only at a period boundary, and the output never glitches.
REQ-013 When en[i]=1, sync=0 and dact>0:
- if cnt==dact-1, cnt SHALL wrap to 0 and tick[i] SHALL be 1 in the following cycle;
- otherwise cnt SHALL increment by 1 and tick[i] SHALL be 0 in the following cycle.
REQ-014 Square mode: clk_out[i] SHALL toggle in the same cycle tick[i] asserts. Output period = 2*dact clocks, 50% duty.
REQ-015 Pulse mode: clk_out[i] SHALL equal tick[i], giving one high cycle every dact clocks.
REQ-016 dact==0 SHALL stall the channel: cnt held at 0, tick 0, clk_out 0, until a nonzero divisor is captured.
REQ-017 dact==1: square mode toggles every clock (clock/2); pulse mode holds clk_out and tick at 1 continuously.
REQ-018 en[i] low SHALL clear cnt, tick[i] and clk_out[i] to 0 on the next edge.
REQ-019 After en[i] rises, the first tick SHALL assert dact clocks after the first enabled edge.
REQ-020 sync=1 SHALL clear cnt, tick and clk_out of every channel to 0 and reload dact.
- sync overrides a coincident wrap.
- On the first cycle after sync deasserts, all enabled channels with equal divisors are phase-aligned.
REQ-021 A mode change SHALL take effect at the next edge.
- Switching to square mode starts from clk_out=0.
- cnt is unaffected.
REQ-022 Channels SHALL be fully independent. There SHALL be no combinational path from any input to clk_out or tick.
REQ-023 Counter arithmetic SHALL be unsigned CNT_W-bit. The maximum divisor is 2^CNT_W-1, and no overflow is possible because wrap occurs at dact-1.

Reset
REQ-024 While rst=0, every channel SHALL immediately force cnt=0, dact=0, tick=0 and clk_out=0, independent of the clock.
REQ-025 On rst release, the first rising edge SHALL capture divisor into dact; counting begins on the following edge if en=1.
REQ-026 Reset asserted mid-period SHALL abort the period. There SHALL be no partial pulse and no retained count after release.

Verification
REQ-027 NUM_CH=2, CNT_W=20, ch0 divisor=5, mode=0, en=1, rst released at 100 ns with a 10 ns clock: clk_out[0] has period 100 ns and 50% duty, and tick[0] fires every 5 clocks.
REQ-028 ch1 divisor=3, mode=1: clk_out[1] is high for 1 of every 3 clocks, and ch0 timing is unchanged.
REQ-029 Change ch0 divisor 5->2 mid-period at cnt=1: the current period completes at 5 clocks, and the following periods are 2 clocks per half.
REQ-030 sync pulse for 1 cycle with both channels set to divisor=4, mode=0: both clk_out are 0 after sync and toggle on the same edge 4 clocks later.
REQ-031 en[0] low for 3 cycles mid-period, then high: clk_out[0]=0 within 1 clock, and the first tick arrives 5 clocks after re-enable.
REQ-032 divisor=0 and divisor=1 on ch0, plus rst pulsed low mid-period: divisor=0 gives a stalled channel with outputs 0; divisor=1 gives clock/2 in square mode and constant 1 in pulse mode; the rst pulse clears all outputs asynchronously.
